fft_output_unloader: RTL and testbench

Reader-side end of the parallel FFT datapath. Captures one complete 32-point complex frame from the final butterfly stage's parallel outputs in a single cycle. Streams the frame out one complex sample per cycle over a valid/ready handshake, optionally undoing bit-reversed ordering. Sits between the last FFT stage and any serial consumer (DMA, UART bridge, magnitude block).

---
 rtl/fft_output_unloader.sv | 103 ++++++++++
 tb/tb_fft_output_unloader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_unloader.sv
// rtl/fft_output_unloader.sv - captures a 32-point complex FFT frame and streams it out one sample per handshake

module fft_output_unloader #(
    parameter int DATA_WIDTH  = 8,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [32*DATA_WIDTH-1:0]   frame_real,
    input  logic [32*DATA_WIDTH-1:0]   frame_imag,
    output logic                       load_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_real,
    output logic [DATA_WIDTH-1:0]      out_imag,
    output logic [4:0]                 out_index,
    output logic                       out_last,
    output logic                       overrun
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                 state, state_next;
    logic [4:0]             k, k_next;
    logic                   capture;
    logic [4:0]             slot;
    logic [DATA_WIDTH-1:0]  mem_real [32];
    logic [DATA_WIDTH-1:0]  mem_imag [32];

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    always_comb begin
        state_next = state;
        k_next     = k;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    capture    = 1'b1;
                    k_next     = 5'd0;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                // 5-bit counter wraps 31 -> 0 on the final handshake
                if (out_ready) begin
                    k_next = k + 5'd1;
                    if (k == 5'd31) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                k_next     = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            k       <= 5'd0;
            overrun <= 1'b0;
        end else begin
            state <= state_next;
            k     <= k_next;
            if (load && state == STREAM) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mem_real[i] <= '0;
                mem_imag[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < 32; i++) begin
                mem_real[i] <= frame_real[i*DATA_WIDTH +: DATA_WIDTH];
                mem_imag[i] <= frame_imag[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Outputs depend only on registered state, counter and storage
    assign slot       = BIT_REVERSE ? bitrev5(k) : k;
    assign load_ready = (state == IDLE);
    assign out_valid  = (state == STREAM);
    assign out_index  = k;
    assign out_last   = (state == STREAM) && (k == 5'd31);
    assign out_real   = mem_real[slot];
    assign out_imag   = mem_imag[slot];

endmodule

// File: tb/tb_fft_output_unloader.sv
// tb/tb_fft_output_unloader.sv - scoreboard bench for fft_output_unloader in both output orderings

module tb_fft_output_unloader;

    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] r;
        logic [DW-1:0] i;
        logic [4:0]    idx;
        logic          last;
    } samp_t;

    logic            clk;
    logic            reset;
    logic            load;
    logic [32*DW-1:0] frame_real;
    logic [32*DW-1:0] frame_imag;
    logic            out_ready;

    logic            lr1, ov1, last1, ovr1;
    logic [DW-1:0]   r1, i1;
    logic [4:0]      x1;
    logic            lr0, ov0, last0, ovr0;
    logic [DW-1:0]   r0, i0;
    logic [4:0]      x0;

    logic [DW-1:0]   ref_r [32];
    logic [DW-1:0]   ref_i [32];
    samp_t           sb1 [$];
    samp_t           sb0 [$];

    int checks = 0;
    int errors = 0;

    fft_output_unloader #(.DATA_WIDTH(DW), .BIT_REVERSE(1'b1)) dut_rev (
        .clk(clk), .reset(reset), .load(load),
        .frame_real(frame_real), .frame_imag(frame_imag),
        .load_ready(lr1), .out_valid(ov1), .out_ready(out_ready),
        .out_real(r1), .out_imag(i1), .out_index(x1),
        .out_last(last1), .overrun(ovr1)
    );

    fft_output_unloader #(.DATA_WIDTH(DW), .BIT_REVERSE(1'b0)) dut_nat (
        .clk(clk), .reset(reset), .load(load),
        .frame_real(frame_real), .frame_imag(frame_imag),
        .load_ready(lr0), .out_valid(ov0), .out_ready(out_ready),
        .out_real(r0), .out_imag(i0), .out_index(x0),
        .out_last(last0), .overrun(ovr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] rev(input logic [4:0] v);
        logic [4:0] o;
        for (int b = 0; b < 5; b++) o[4-b] = v[b];
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_ovr);
        chk({tag, "_load_ready"}, lr1, 1);
        chk({tag, "_out_valid"}, ov1, 0);
        chk({tag, "_out_last"}, last1, 0);
        chk({tag, "_overrun"}, ovr1, exp_ovr);
        chk({tag, "_load_ready_nat"}, lr0, 1);
        chk({tag, "_out_valid_nat"}, ov0, 0);
        chk({tag, "_overrun_nat"}, ovr0, exp_ovr);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        load      = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        load  = 1'b0;
        sb1.delete();
        sb0.delete();
    endtask

    task automatic do_load();
        samp_t s;
        for (int j = 0; j < 32; j++) begin
            frame_real[j*DW +: DW] = ref_r[j];
            frame_imag[j*DW +: DW] = ref_i[j];
        end
        chk("pre_load_ready", lr1, 1);
        for (int k = 0; k < 32; k++) begin
            s.idx  = 5'(k);
            s.last = (k == 31);
            s.r    = ref_r[rev(5'(k))];
            s.i    = ref_i[rev(5'(k))];
            sb1.push_back(s);
            s.r    = ref_r[k];
            s.i    = ref_i[k];
            sb0.push_back(s);
        end
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic stream(input int stall_at, input int stall_len, input int ovr_at, input int stop_at);
        int   stalls = 0;
        int   cyc = 0;
        bit   hit_ovr = 0;
        logic rdy;
        while (sb1.size() > 0 && cyc < 100) begin
            if (int'(sb1[0].idx) == stop_at) break;
            chk("out_valid", ov1, 1);
            chk("out_real", r1, sb1[0].r);
            chk("out_imag", i1, sb1[0].i);
            chk("out_index", x1, sb1[0].idx);
            chk("out_last", last1, sb1[0].last);
            chk("out_valid_nat", ov0, 1);
            chk("out_real_nat", r0, sb0[0].r);
            chk("out_imag_nat", i0, sb0[0].i);
            chk("out_index_nat", x0, sb0[0].idx);
            chk("out_last_nat", last0, sb0[0].last);
            rdy = 1'b1;
            if (int'(sb1[0].idx) == stall_at && stalls < stall_len) begin
                rdy = 1'b0;
                stalls++;
            end
            out_ready = rdy;
            if (int'(sb1[0].idx) == ovr_at && rdy && !hit_ovr) begin
                frame_real = {32{8'hAA}};
                frame_imag = {32{8'hAA}};
                load       = 1'b1;
                hit_ovr    = 1;
            end
            if (rdy) begin
                void'(sb1.pop_front());
                void'(sb0.pop_front());
            end
            tick();
            load = 1'b0;
            cyc++;
        end
        out_ready = 1'b0;
        if (stop_at < 0) chk("stream_drained", sb1.size(), 0);
    endtask

    initial begin
        reset      = 1'b0;
        load       = 1'b0;
        out_ready  = 1'b0;
        frame_real = '0;
        frame_imag = '0;
        for (int j = 0; j < 32; j++) begin
            ref_r[j] = 8'(j);
            ref_i[j] = 8'hFF - 8'(j);
        end
        tick();

        do_reset();
        check_idle("reset", 1'b0);
        chk("reset_out_real", r1, 0);
        chk("reset_out_imag", i1, 0);
        chk("reset_out_index", x1, 0);

        do_load();
        stream(-1, 0, -1, -1);
        check_idle("frame_end", 1'b0);

        do_load();
        stream(3, 5, -1, -1);
        check_idle("backpressure_end", 1'b0);

        do_load();
        stream(-1, 0, 10, -1);
        check_idle("overrun_mid", 1'b1);

        do_reset();
        check_idle("reset2", 1'b0);
        do_load();
        stream(-1, 0, 31, -1);
        check_idle("overrun_last", 1'b1);

        do_load();
        stream(-1, 0, -1, 10);
        chk("mid_index_before_reset", x1, 10);
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b0;
        sb1.delete();
        sb0.delete();
        check_idle("mid_reset", 1'b0);
        chk("mid_reset_out_real", r1, 0);

        for (int j = 0; j < 32; j++) begin
            ref_r[j] = 8'($urandom);
            ref_i[j] = 8'($urandom);
        end
        do_load();
        stream(17, 2, -1, -1);
        check_idle("random_end", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
